updown_mod_counter: RTL
=======================

// Module: updown_mod_counter
// PURPOSE
//   Parametrised up/down modulo counter; next generation of the fixed 4-bit counter.
//   Adds programmable limit, wrap/saturate mode, sync load/clear, enable prescaler,
//   terminal-count and overflow flags. Used as a general timer/event counter in datapath control.
// PARAMETERS
//   WIDTH     4  counter width in bits (>=2)
//   PRESCALE  1  enabled cycles per count step (>=1; 1 = step on every enabled cycle)
// PORTS
//   clk       in   1      rising-edge clock
//   reset_n   in   1      asynchronous, active-low reset
//   clr       in   1      synchronous clear of count, prescaler, ovf
//   load      in   1      synchronous load of load_val; prescaler cleared
//   load_val  in   WIDTH  value for load
//   en        in   1      count enable, gated by prescaler
//   up        in   1      1 = count up, 0 = count down
//   sat_mode  in   1      0 = wrap at boundary, 1 = saturate at boundary
//   limit     in   WIDTH  upper bound; count range is 0..limit
//   count     out  WIDTH  registered count value
//   tc        out  1      combinational: up ? (count>=limit) : (count==0)
//   wrap      out  1      registered one-cycle pulse, high the cycle after a wrap
//   ovf       out  1      sticky: set by any wrap or any step blocked by saturation
// BEHAVIOUR
//   - Reset (reset_n=0, async): count=0, wrap=0, ovf=0, prescaler=0. Outputs valid in reset.
//   - Priority per edge: clr > load > step. clr: count=0, ovf=0, presc=0, wrap=0.
//     load: count=load_val (accepted even if >limit), presc=0, wrap=0, ovf unchanged.
//   - Prescaler: presc counts en cycles 0..PRESCALE-1; step = en & (presc==PRESCALE-1);
//     presc returns to 0 on step. en=0 holds presc. PRESCALE=1 -> step=en, no register.
//   - Step, up=1: count<limit -> count+1. count>=limit -> wrap mode: count=0, wrap=1, ovf=1;
//     saturate mode: count=limit, ovf=1 (no wrap pulse).
//   - Step, up=0: count>0 -> count-1. count==0 -> wrap mode: count=limit, wrap=1, ovf=1;
//     saturate mode: count stays 0, ovf=1.
//   - count>limit (limit lowered or oversized load): treated as boundary on next up step;
//     down step from count>limit decrements normally.
//   - limit=0: every step is a boundary event; count stays/returns to 0.
//   - No step: count holds, wrap=0. Latency: count changes on the step edge, visible after it.
//   - up, sat_mode, limit sampled only on step edges; may change any cycle.
//   - Arithmetic modulo 2^WIDTH is never reached: boundary checks precede +/-1.
// STRUCTURE
//   - Shared package updown_counter_pkg: CNT_UP/CNT_DOWN and MODE_WRAP/MODE_SAT constants.
//   - Sub-module cnt_prescaler (PRESCALE param; clk, reset_n, clr, en -> step);
//     generate bypass when PRESCALE==1.
//   - Top: one always block for count/wrap/ovf, one assign for tc.
// TESTING (WIDTH=4 unless noted)
//   1. reset_n=0 mid-count (count=7) -> count=0, wrap=0, ovf=0 immediately, before next edge.
//   2. limit=15, wrap, up, en=1 for 16 cycles -> count 1..15 then 0; wrap high one cycle after 0; ovf=1.
//   3. limit=9, wrap, up -> 0..9,0; tc=1 exactly while count=9; ovf cleared by clr -> 0.
//   4. limit=5, sat_mode=1, up, 8 steps -> count holds 5, ovf set on 6th step, wrap never high.
//   5. load_val=2, up=0, limit=9, wrap -> 2,1,0,9; tc=1 at 0; clr+load+en same edge -> count=0;
//      load+en same edge -> count=load_val.
//   6. PRESCALE=3: en=1 -> count +1 every 3 cycles; en low 2 cycles mid-period holds phase;
//      load clears prescaler so next step is 3 enabled cycles after the load.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// Shared constants for the up/down modulo counter family: direction and
// boundary-mode encodings used by the counter and its users.
package updown_counter_pkg;

   // Direction select on the 'up' input
   localparam logic CNT_UP    = 1'b1;
   localparam logic CNT_DOWN  = 1'b0;

   // Boundary behaviour select on the 'sat_mode' input
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

endpackage : updown_counter_pkg

// File: rtl/cnt_prescaler.sv
// Enable prescaler: turns every PRESCALE-th enabled cycle into a single
// step strobe. With PRESCALE==1 the enable passes straight through and no
// state is kept.
module cnt_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic step
);

   generate
      if (PRESCALE <= 1) begin : g_bypass
         // Clock, reset and clear have nothing to act on in bypass mode
         logic unused_bypass;
         assign unused_bypass = clk ^ reset_n ^ clr;

         assign step = en;
      end else begin : g_divide
         localparam int               PW   = $clog2(PRESCALE);
         localparam logic [PW-1:0]    LAST = PW'(PRESCALE - 1);
         localparam logic [PW-1:0]    ONE  = PW'(1);

         logic [PW-1:0] presc_reg;

         assign step = en && (presc_reg == LAST);

         // Count enabled cycles; restart the period on a step or a clear
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               presc_reg <= '0;
            end else if (clr) begin
               presc_reg <= '0;
            end else if (en) begin
               if (presc_reg == LAST) begin
                  presc_reg <= '0;
               end else begin
                  presc_reg <= presc_reg + ONE;
               end
            end
         end
      end
   endgenerate

endmodule : cnt_prescaler

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with programmable upper limit,
// wrap/saturate boundary handling, synchronous clear/load, prescaled
// enable, terminal-count, wrap pulse and sticky overflow flags.
module updown_mod_counter
   import updown_counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   input  logic             sat_mode,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_reg;
   logic             wrap_reg;
   logic             ovf_reg;
   logic             step;

   // A load restarts the prescaler period just like a clear does
   cnt_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_presc (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr | load),
      .en      (en),
      .step    (step)
   );

   // Count, wrap pulse and sticky overflow; clr beats load beats step.
   // Boundary tests come before +/-1 so the register never rolls over
   // modulo 2^WIDTH; a count above limit counts as an up-boundary.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
         wrap_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else if (clr) begin
         count_reg <= '0;
         wrap_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else if (load) begin
         count_reg <= load_val;
         wrap_reg  <= 1'b0;
      end else if (step) begin
         if (up == CNT_UP) begin
            if (count_reg < limit) begin
               count_reg <= count_reg + ONE;
               wrap_reg  <= 1'b0;
            end else if (sat_mode == MODE_WRAP) begin
               count_reg <= '0;
               wrap_reg  <= 1'b1;
               ovf_reg   <= 1'b1;
            end else begin
               count_reg <= limit;
               wrap_reg  <= 1'b0;
               ovf_reg   <= 1'b1;
            end
         end else begin
            if (count_reg != '0) begin
               count_reg <= count_reg - ONE;
               wrap_reg  <= 1'b0;
            end else if (sat_mode == MODE_WRAP) begin
               count_reg <= limit;
               wrap_reg  <= 1'b1;
               ovf_reg   <= 1'b1;
            end else begin
               wrap_reg  <= 1'b0;
               ovf_reg   <= 1'b1;
            end
         end
      end else begin
         wrap_reg <= 1'b0;
      end
   end

   assign tc    = (up == CNT_UP) ? (count_reg >= limit) : (count_reg == '0);
   assign count = count_reg;
   assign wrap  = wrap_reg;
   assign ovf   = ovf_reg;

endmodule : updown_mod_counter
